// File: rtl/fsm1_pkg.sv
// Shared types and constants for the fsm1 pulse driver and its stimulus FIFO.
package fsm1_pkg;

  // Bit positions of the fields inside a raw 3-bit stimulus vector.
  localparam int STIM_IN1_BIT = 0;
  localparam int STIM_IN2_BIT = 1;
  localparam int STIM_RST_BIT = 2;
  localparam int STIM_W       = 3;

  // One FSM period's worth of stimulus: {reset, input2, input1}.
  typedef struct packed {
    logic rst;
    logic in2;
    logic in1;
  } stim_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  // Unpack a raw vector into named fields using the index constants above.
  function automatic stim_t to_stim(input logic [STIM_W-1:0] bits);
    stim_t s;
    s.rst = bits[STIM_RST_BIT];
    s.in2 = bits[STIM_IN2_BIT];
    s.in1 = bits[STIM_IN1_BIT];
    return s;
  endfunction

endpackage

// File: rtl/fsm1_stim_fifo.sv
// Small synchronous FIFO holding queued stimulus vectors.
// Push is a valid/ready handshake where ready is !o_full; pop is a strobe
// that is ignored while empty. Pointers wrap naturally because DEPTH is a
// power of two. The storage array is not reset; emptiness is tracked by the
// occupancy counter, so a reset empties the FIFO regardless of contents.
module fsm1_stim_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push_valid,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push_valid && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rdPtr];

  // Storage write; contents only matter while counted as occupied.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fsm1_pulse_driver.sv
// Stimulus sequencer for fsm1_route: turns queued {reset, input2, input1}
// vectors into narrow data pulses at mid-period plus a periodic FSM clock
// pulse at the end of each period, all on the fast GCLK_Pad timebase.
//
// All pulse outputs are registered from the *next* state and tick, so an
// output register holds the value belonging to the tick the counter shows
// in the same cycle. The head vector is popped on the edge that enters the
// DATA_OFS tick.
module fsm1_pulse_driver
  import fsm1_pkg::*;
#(
  parameter int PERIOD   = 40,
  parameter int CLK_W    = 1,
  parameter int DATA_OFS = 20,
  parameter int DATA_W   = 1,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 16
) (
  input  logic             GCLK_Pad,
  input  logic             reset_n_Pad,
  input  logic             run,
  input  logic             stim_valid,
  input  logic [2:0]       stim_data,
  output logic             stim_ready,
  output logic             fsm_clk_o,
  output logic             input1_o,
  output logic             input2_o,
  output logic             reset_o,
  output logic             period_strobe,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] idle_count,
  output logic             busy
);

  localparam int TICK_W = $clog2(PERIOD);
  localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(PERIOD - 1);
  localparam logic [TICK_W-1:0] CLK_START  = TICK_W'(PERIOD - CLK_W);
  localparam logic [TICK_W-1:0] DATA_START = TICK_W'(DATA_OFS);
  localparam logic [TICK_W-1:0] DATA_END   = TICK_W'(DATA_OFS + DATA_W - 1);

  state_e              r_state;
  state_e              w_stateNext;
  logic [TICK_W-1:0]   r_tick;
  logic [TICK_W-1:0]   w_tickNext;
  logic                w_lastTick;
  logic                w_activeNext;
  logic                w_dataTick;
  logic                w_dataWindow;
  logic                w_pop;
  logic                w_fifoFull;
  logic                w_fifoEmpty;
  logic [STIM_W-1:0]   w_headBits;
  stim_t               w_head;
  stim_t               r_vec;
  stim_t               w_vecNext;
  logic                r_fsmClk;
  logic                r_strobe;
  logic                r_in1;
  logic                r_in2;
  logic                r_rst;
  logic [CNT_W-1:0]    r_vecCount;
  logic [CNT_W-1:0]    r_idleCount;

  fsm1_stim_fifo #(
    .WIDTH (STIM_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (GCLK_Pad),
    .rst_n        (reset_n_Pad),
    .i_push_valid (stim_valid),
    .i_push_data  (stim_data),
    .i_pop        (w_pop),
    .o_head       (w_headBits),
    .o_full       (w_fifoFull),
    .o_empty      (w_fifoEmpty)
  );

  // Ready is held low while reset is asserted so nothing appears accepted.
  assign stim_ready   = reset_n_Pad && !w_fifoFull;
  assign w_head       = to_stim(w_headBits);
  assign w_lastTick   = (r_tick == LAST_TICK);
  assign w_activeNext = (w_stateNext != IDLE);
  assign w_dataTick   = w_activeNext && (w_tickNext == DATA_START);
  assign w_pop        = w_dataTick && !w_fifoEmpty;
  assign w_dataWindow = w_activeNext && (w_tickNext >= DATA_START) &&
                        (w_tickNext <= DATA_END);

  // State and tick counter registers.
  always_ff @(posedge GCLK_Pad or negedge reset_n_Pad) begin
    if (!reset_n_Pad) begin
      r_state <= IDLE;
      r_tick  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_tick  <= w_tickNext;
    end
  end

  // Next state and tick: a stop request lets the current period finish,
  // and a run request during the tail of a stop resumes without a gap.
  always_comb begin
    w_stateNext = r_state;
    w_tickNext  = r_tick;
    case (r_state)
      IDLE: begin
        w_tickNext = '0;
        if (run) begin
          w_stateNext = RUN;
        end
      end
      RUN: begin
        w_tickNext = w_lastTick ? '0 : r_tick + TICK_W'(1);
        if (!run) begin
          w_stateNext = w_lastTick ? IDLE : STOPPING;
        end
      end
      STOPPING: begin
        w_tickNext = w_lastTick ? '0 : r_tick + TICK_W'(1);
        if (run) begin
          w_stateNext = RUN;
        end else if (w_lastTick) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_tickNext  = '0;
      end
    endcase
  end

  // Vector held for this period's data window: loaded from the FIFO head on
  // a pop, cleared when the data tick finds the FIFO empty.
  always_comb begin
    w_vecNext = r_vec;
    if (w_dataTick) begin
      w_vecNext = w_pop ? w_head : '0;
    end
  end

  // Registered pulse outputs, including the held data vector.
  always_ff @(posedge GCLK_Pad or negedge reset_n_Pad) begin
    if (!reset_n_Pad) begin
      r_vec    <= '0;
      r_fsmClk <= 1'b0;
      r_strobe <= 1'b0;
      r_in1    <= 1'b0;
      r_in2    <= 1'b0;
      r_rst    <= 1'b0;
    end else begin
      r_vec    <= w_vecNext;
      r_fsmClk <= w_activeNext && (w_tickNext >= CLK_START);
      r_strobe <= w_activeNext && (w_tickNext == CLK_START);
      r_in1    <= w_dataWindow && w_vecNext.in1;
      r_in2    <= w_dataWindow && w_vecNext.in2;
      r_rst    <= w_dataWindow && w_vecNext.rst;
    end
  end

  // Saturating statistics: issued vectors and periods that found no data.
  always_ff @(posedge GCLK_Pad or negedge reset_n_Pad) begin
    if (!reset_n_Pad) begin
      r_vecCount  <= '0;
      r_idleCount <= '0;
    end else begin
      if (w_pop && (r_vecCount != '1)) begin
        r_vecCount <= r_vecCount + CNT_W'(1);
      end
      if (w_dataTick && w_fifoEmpty && (r_idleCount != '1)) begin
        r_idleCount <= r_idleCount + CNT_W'(1);
      end
    end
  end

  assign fsm_clk_o     = r_fsmClk;
  assign period_strobe = r_strobe;
  assign input1_o      = r_in1;
  assign input2_o      = r_in2;
  assign reset_o       = r_rst;
  assign vec_count     = r_vecCount;
  assign idle_count    = r_idleCount;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_fsm1_pulse_driver.sv
// Bench for fsm1_pulse_driver: a per-cycle reference model (period phase,
// running flag and a vector queue) checks every cycle, a table drives the
// ordered-vector test, and hand-written sequences cover the FIFO-full,
// stop, mid-pulse reset and counter saturation corners.
module tb_fsm1_pulse_driver;

  localparam int PERIOD   = 40;
  localparam int CLK_W    = 1;
  localparam int DATA_OFS = 20;
  localparam int DATA_W   = 1;
  localparam int DEPTH    = 8;
  localparam int CNT_W    = 16;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic GCLK_Pad = 1'b0;
  logic reset_n_Pad;
  logic run;
  logic stim_valid;
  logic [2:0] stim_data;
  logic stim_ready, fsm_clk_o, input1_o, input2_o, reset_o, period_strobe, busy;
  logic [CNT_W-1:0] vec_count, idle_count;

  logic satReset_n, satRun, satValid;
  logic [2:0] satData;
  logic sat_ready, sat_clk, sat_in1, sat_in2, sat_rst, sat_strobe, sat_busy;
  logic [3:0] sat_vec_count, sat_idle_count;

  always #5 GCLK_Pad = ~GCLK_Pad;

  fsm1_pulse_driver #(
    .PERIOD(PERIOD), .CLK_W(CLK_W), .DATA_OFS(DATA_OFS),
    .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) u_dut (
    .GCLK_Pad(GCLK_Pad), .reset_n_Pad(reset_n_Pad), .run(run),
    .stim_valid(stim_valid), .stim_data(stim_data), .stim_ready(stim_ready),
    .fsm_clk_o(fsm_clk_o), .input1_o(input1_o), .input2_o(input2_o),
    .reset_o(reset_o), .period_strobe(period_strobe),
    .vec_count(vec_count), .idle_count(idle_count), .busy(busy)
  );

  fsm1_pulse_driver #(
    .PERIOD(8), .CLK_W(1), .DATA_OFS(2), .DATA_W(1), .DEPTH(8), .CNT_W(4)
  ) u_dutSat (
    .GCLK_Pad(GCLK_Pad), .reset_n_Pad(satReset_n), .run(satRun),
    .stim_valid(satValid), .stim_data(satData), .stim_ready(sat_ready),
    .fsm_clk_o(sat_clk), .input1_o(sat_in1), .input2_o(sat_in2),
    .reset_o(sat_rst), .period_strobe(sat_strobe),
    .vec_count(sat_vec_count), .idle_count(sat_idle_count), .busy(sat_busy)
  );

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model state.
  bit         mActive;
  int         mTick;
  logic [2:0] mQ[$];
  logic [2:0] mVec;
  int         mVecCnt, mIdleCnt;

  // Collection of data seen at the data tick and just after the window.
  logic [2:0] gotQ[$];
  logic [2:0] afterQ[$];
  int clkCount, strobeCount;

  typedef struct {
    logic [2:0] data;
    logic       expRst;
    logic       expIn2;
    logic       expIn1;
  } vecRec_t;
  vecRec_t tbl[5];

  logic [2:0] fullVecs[9];
  logic [2:0] stopVecs[5];
  int  prevTick, accepted, prevCnt;
  bit  done, wrapped, runLevel;
  logic preReady;

  task automatic checkValue(input string name, input longint actual, input longint expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, want %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mActive = 0; mTick = 0; mQ.delete(); mVec = '0; mVecCnt = 0; mIdleCnt = 0;
  endtask

  // Advance the model over one rising edge using the inputs being driven.
  task automatic modelEdge();
    int  nTick;
    bit  nActive;
    bit  readyPre;
    if (!reset_n_Pad) begin
      modelReset();
      return;
    end
    readyPre = (mQ.size() < DEPTH);
    if (!mActive) begin
      nActive = run;
      nTick   = 0;
    end else begin
      nTick   = (mTick == PERIOD - 1) ? 0 : mTick + 1;
      nActive = run || (mTick != PERIOD - 1);
    end
    if (nActive && nTick == DATA_OFS) begin
      if (mQ.size() > 0) begin
        mVec = mQ.pop_front();
        if (mVecCnt < CNT_MAX) mVecCnt++;
      end else begin
        mVec = '0;
        if (mIdleCnt < CNT_MAX) mIdleCnt++;
      end
    end
    if (stim_valid && readyPre) mQ.push_back(stim_data);
    mActive = nActive;
    mTick   = nTick;
  endtask

  task automatic checkOutput();
    logic [6:0] expBits, actBits;
    logic win;
    win = mActive && (mTick >= DATA_OFS) && (mTick < DATA_OFS + DATA_W);
    expBits = {mActive, reset_n_Pad && (mQ.size() < DEPTH),
               mActive && (mTick >= PERIOD - CLK_W), mActive && (mTick == PERIOD - CLK_W),
               win & mVec[2], win & mVec[1], win & mVec[0]};
    actBits = {busy, stim_ready, fsm_clk_o, period_strobe, reset_o, input2_o, input1_o};
    checkValue("pulses", actBits, expBits);
    checkValue("vec_count", vec_count, mVecCnt);
    checkValue("idle_count", idle_count, mIdleCnt);
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [2:0] d);
    run = r; stim_valid = v; stim_data = d;
    @(posedge GCLK_Pad);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic stepCollect(input logic r, input logic v, input logic [2:0] d);
    applyStimulus(r, v, d);
    if (mActive && mTick == DATA_OFS) gotQ.push_back({reset_o, input2_o, input1_o});
    if (mActive && mTick == DATA_OFS + DATA_W) afterQ.push_back({reset_o, input2_o, input1_o});
    if (fsm_clk_o) clkCount++;
    if (period_strobe) strobeCount++;
  endtask

  task automatic waitIdle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      stepCollect(1'b0, 1'b0, 3'b000);
      if (!busy) begin ok = 1; break; end
    end
    checkValue(name, ok, 1);
  endtask

  task automatic doReset();
    reset_n_Pad = 1'b0;
    modelReset();
    applyStimulus(1'b0, 1'b0, 3'b000);
    applyStimulus(1'b0, 1'b0, 3'b000);
    reset_n_Pad = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tbl[0] = '{3'b100, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{3'b000, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{3'b011, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{3'b001, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{3'b010, 1'b0, 1'b1, 1'b0};
    fullVecs = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b001, 3'b010};
    stopVecs = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b101};

    satReset_n = 1'b0; satRun = 1'b0; satValid = 1'b0; satData = 3'b000;
    run = 1'b1; stim_valid = 1'b0; stim_data = 3'b000;

    // Reset with run held high, then five free-running empty periods.
    reset_n_Pad = 1'b0;
    modelReset();
    applyStimulus(1'b1, 1'b0, 3'b000);
    applyStimulus(1'b1, 1'b0, 3'b000);
    reset_n_Pad = 1'b1;
    satReset_n = 1'b1;
    #1;
    checkValue("ready_after_release", stim_ready, 1);
    checkValue("busy_after_release", busy, 0);
    for (int c = 0; c < 5 * PERIOD; c++) begin
      applyStimulus(1'b1, 1'b0, 3'b000);
      checkValue("clk_at_tick", fsm_clk_o, (c % PERIOD) == PERIOD - 1);
      if (c % PERIOD == DATA_OFS)
        checkValue("no_data_empty", {reset_o, input2_o, input1_o}, 0);
    end
    checkValue("idle_count_5", idle_count, 5);
    checkValue("vec_count_0", vec_count, 0);
    applyStimulus(1'b0, 1'b0, 3'b000);
    checkValue("busy_after_stop", busy, 0);

    // Table of five vectors queued before run, issued one per period.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, tbl[i].data);
    gotQ.delete(); afterQ.delete(); clkCount = 0; strobeCount = 0;
    for (int i = 0; i < 10 * PERIOD; i++) begin
      stepCollect(1'b1, 1'b0, 3'b000);
      if (gotQ.size() == 5 && afterQ.size() == 5) break;
    end
    waitIdle("table_stop");
    checkValue("table_collected", gotQ.size(), 5);
    for (int p = 0; p < 5; p++) begin
      if (p < gotQ.size()) begin
        checkValue("table_pulse", gotQ[p], {tbl[p].expRst, tbl[p].expIn2, tbl[p].expIn1});
        checkValue("table_width", afterQ[p], 0);
      end
    end
    checkValue("table_vec_count", vec_count, 5);
    checkValue("table_clk_count", clkCount, 5);
    checkValue("table_strobe_count", strobeCount, 5);

    // Fill the FIFO, hold a ninth vector, and start running.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, fullVecs[i]);
    checkValue("ready_when_full", stim_ready, 0);
    gotQ.delete();
    done = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      preReady = stim_ready;
      prevTick = mTick;
      stepCollect(1'b1, 1'b1, fullVecs[8]);
      if (preReady) begin
        checkValue("accept_tick", prevTick, DATA_OFS);
        done = 1;
        break;
      end
    end
    checkValue("accept_9th", done, 1);
    for (int i = 0; i < 12 * PERIOD; i++) begin
      if (gotQ.size() >= 9) break;
      stepCollect(1'b1, 1'b0, 3'b000);
    end
    waitIdle("full_stop");
    checkValue("full_collected", gotQ.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < gotQ.size()) checkValue("full_order", gotQ[i], fullVecs[i]);

    // Stop at tick 5 of the third period; leftovers issue after restart.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, stopVecs[i]);
    gotQ.delete();
    done = 0;
    for (int i = 0; i < 4 * PERIOD; i++) begin
      stepCollect(1'b1, 1'b0, 3'b000);
      if (gotQ.size() == 2 && mTick == 5) begin done = 1; break; end
    end
    checkValue("reach_period3", done, 1);
    clkCount = 0;
    done = 0;
    prevTick = -1;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      prevTick = mTick;
      stepCollect(1'b0, 1'b0, 3'b000);
      if (!busy) begin done = 1; break; end
    end
    checkValue("stop_busy_fall", done, 1);
    checkValue("stop_last_tick", prevTick, PERIOD - 1);
    checkValue("stop_clk_pulses", clkCount, CLK_W);
    checkValue("stop_collected", gotQ.size(), 3);
    if (gotQ.size() >= 3) checkValue("stop_third", gotQ[2], stopVecs[2]);
    checkValue("stop_vec_count", vec_count, 17);
    for (int i = 0; i < 30; i++) stepCollect(1'b0, 1'b0, 3'b000);
    checkValue("stopped_no_clk", clkCount, CLK_W);
    for (int i = 0; i < 4 * PERIOD; i++) begin
      if (gotQ.size() >= 5) break;
      stepCollect(1'b1, 1'b0, 3'b000);
    end
    waitIdle("resume_stop");
    checkValue("resume_collected", gotQ.size(), 5);
    if (gotQ.size() >= 5) begin
      checkValue("resume_fourth", gotQ[3], stopVecs[3]);
      checkValue("resume_fifth", gotQ[4], stopVecs[4]);
    end

    // Randomised run/stop and push traffic against the model.
    runLevel = 1;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 99) == 0) runLevel = ~runLevel;
      applyStimulus(runLevel, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
    end

    // Reset in the middle of a data pulse.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 3'b111);
    done = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      stepCollect(1'b1, 1'b0, 3'b000);
      if (mActive && mTick == DATA_OFS) begin done = 1; break; end
    end
    checkValue("reach_pulse", done, 1);
    checkValue("pre_reset_pulse", {reset_o, input2_o, input1_o}, 3'b111);
    reset_n_Pad = 1'b0;
    modelReset();
    #1;
    checkValue("reset_outputs",
               {busy, stim_ready, fsm_clk_o, period_strobe, reset_o, input2_o, input1_o}, 0);
    checkValue("reset_vec_count", vec_count, 0);
    checkValue("reset_idle_count", idle_count, 0);
    applyStimulus(1'b1, 1'b0, 3'b000);
    applyStimulus(1'b1, 1'b0, 3'b000);
    reset_n_Pad = 1'b1;
    for (int c = 0; c < PERIOD; c++) begin
      applyStimulus(1'b1, 1'b0, 3'b000);
      checkValue("post_reset_clk", fsm_clk_o, c == PERIOD - 1);
      if (c == DATA_OFS) checkValue("post_reset_data", {reset_o, input2_o, input1_o}, 0);
    end
    checkValue("post_reset_idle", idle_count, 1);
    checkValue("post_reset_vec", vec_count, 0);
    applyStimulus(1'b0, 1'b0, 3'b000);

    // Saturation on the narrow-counter instance: 17 vectors into 4 bits.
    accepted = 0; prevCnt = 0; wrapped = 0;
    satRun = 1'b1;
    for (int c = 0; c < 400; c++) begin
      satValid = (accepted < 17);
      satData = 3'b001;
      preReady = sat_ready;
      @(posedge GCLK_Pad);
      if (satValid && preReady) accepted++;
      #1;
      if (int'(sat_vec_count) < prevCnt) wrapped = 1;
      prevCnt = int'(sat_vec_count);
    end
    checkValue("sat_accepted", accepted, 17);
    checkValue("sat_vec_count", sat_vec_count, 15);
    checkValue("sat_no_wrap", wrapped, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
